// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, ALU
// opcodes, datapath mux selects, opcodes and small decode helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC,
        S_LUI, S_HALT
    } state_t;

    typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_FUNCT} alu_class_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    function automatic logic op_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    endfunction

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic branch_f3_legal(input logic [2:0] funct3);
        return funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
    endfunction

    // blt/bge use the raw sign of RD1-RD2; overflow is deliberately not corrected
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic neg);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return neg;
            3'b101:  return !neg;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU class plus funct3/funct7_5 onto the ALU opcode and
// flags funct3 values that name no supported ALU operation.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        is_rtype,
    output logic [2:0]  alu_opcode,
    output logic        illegal
);

    // illegal depends on funct3 alone so decode can vet it ahead of execute
    always_comb begin
        alu_opcode = ALU_ADD;
        illegal    = (funct3 == 3'b001) || (funct3 == 3'b101);
        case (alu_class)
            CLS_SUB: alu_opcode = ALU_SUB;
            CLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_opcode = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_opcode = ALU_SLT;
                    3'b011:  alu_opcode = ALU_SLTU;
                    3'b100:  alu_opcode = ALU_XOR;
                    3'b110:  alu_opcode = ALU_OR;
                    3'b111:  alu_opcode = ALU_AND;
                    default: alu_opcode = ALU_ADD;
                endcase
            end
            default: alu_opcode = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/execute/mem/wb).
// Define ILLEGAL_TRAP_EN to trap unsupported instructions in a sticky HALT state.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       neg,
    output logic [2:0] alu_opcode,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t     state, next;
    alu_class_t alu_class;
    logic       f3_illegal, op_bad, f3_bad;

    alu_decoder u_alu_decoder (
        .alu_class  (alu_class),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .is_rtype   (op == OP_R),
        .alu_opcode (alu_opcode),
        .illegal    (f3_illegal)
    );

    assign op_bad = !op_legal(op);
    assign f3_bad = ((op == OP_R || op == OP_I) && f3_illegal) ||
                    (op == OP_BR && !branch_f3_legal(funct3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH: next = S_DECODE;
            S_DECODE: begin
                if (op_bad)                 next = TRAP_EN ? S_HALT : S_FETCH;
                else if (TRAP_EN && f3_bad) next = S_HALT;
                else begin
                    case (op)
                        OP_LW, OP_SW: next = S_MEM_ADR;
                        OP_R:         next = S_EXEC_R;
                        OP_I:         next = S_EXEC_I;
                        OP_BR:        next = S_BRANCH;
                        OP_JAL:       next = S_JAL;
                        OP_JALR:      next = S_JALR;
                        OP_LUI:       next = S_LUI;
                        default:      next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADR:  next = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: next = S_MEM_WB;
            S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_PC: next = S_ALU_WB;
            S_JALR:     next = S_JALR_PC;
            S_HALT:     next = S_HALT;
            default:    next = S_FETCH;
        endcase
    end

    always_comb begin
        alu_class  = CLS_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_src_of(op);
            end
            S_MEM_ADR, S_JALR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: adr_src = 1'b1;
            S_MEM_WB: begin
                adr_src    = 1'b1;
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RD1;
                alu_class = CLS_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_class = CLS_FUNCT;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_class = CLS_SUB;
                pc_write  = branch_taken(funct3, zero, neg);
            end
            // PC takes the target latched in ALUOut while the ALU forms the link
            S_JAL, S_JALR_PC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_write  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: illegal = 1'b1;
`endif
            default: ;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle tables built from the
// instruction rules, directed cases with literal pins, then random instructions.
module tb_multicycle_controller;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic [2:0] alu_opcode;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic       adr_src, pc_write, ir_write, mem_write, reg_write, illegal;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .neg(neg), .alu_opcode(alu_opcode), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] aop;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [2:0] imm;
        logic adr, pcw, irw, mw, rw, ill;
    } outs_t;

    int    total = 0;
    int    bad = 0;
    outs_t exp_q[$];
    int    br_idx;
    bit    halted;
    outs_t obs[8];

    function automatic outs_t sample();
        return {alu_opcode, alu_src_a, alu_src_b, result_src, imm_src,
                adr_src, pc_write, ir_write, mem_write, reg_write, illegal};
    endfunction

    function automatic outs_t o_fetch();
        outs_t o = '0;
        o.sb = 2'b10; o.rs = 2'b10; o.irw = 1'b1; o.pcw = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_reset();
        outs_t o = o_fetch();
        o.pcw = 1'b0; o.irw = 1'b0;
        return o;
    endfunction

    function automatic outs_t o_alu(input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] aop);
        outs_t o = '0;
        o.sa = sa; o.sb = sb; o.aop = aop;
        return o;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7, input bit r);
        case (f3)
            3'd0:    return (r && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd3:    return 3'd4;
            3'd4:    return 3'd6;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic n);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return n;
        if (f3 == 3'd5) return !n;
        return 1'b0;
    endfunction

    // Expected per-cycle outputs of one instruction, cycle 1 = fetch
    task automatic build(input logic [6:0] o7, input logic [2:0] f3, input logic f7);
        outs_t d, wb;
        bit    known, f3bad;
        exp_q.delete();
        br_idx = -1;
        halted = 1'b0;
        known  = o7 inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37};
        f3bad  = ((o7 == 7'h33 || o7 == 7'h13) && (f3 == 3'd1 || f3 == 3'd5)) ||
                 (o7 == 7'h63 && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5}));
        exp_q.push_back(o_fetch());
        d = o_alu(2'b01, 2'b01, 3'd0);
        d.imm = (o7 == 7'h23) ? 3'd1 : (o7 == 7'h63) ? 3'd2 : (o7 == 7'h6f) ? 3'd3 :
                (o7 == 7'h37) ? 3'd4 : 3'd0;
        exp_q.push_back(d);
        wb = '0; wb.rw = 1'b1;
        if (!known || (TRAP && f3bad)) begin
            if (TRAP) begin
                d = '0; d.ill = 1'b1;
                repeat (3) exp_q.push_back(d);
                halted = 1'b1;
            end
        end else begin
            case (o7)
                7'h03: begin
                    exp_q.push_back(o_alu(2'b10, 2'b01, 3'd0));
                    d = '0; d.adr = 1'b1; exp_q.push_back(d);
                    d.rs = 2'b01; d.rw = 1'b1; exp_q.push_back(d);
                end
                7'h23: begin
                    exp_q.push_back(o_alu(2'b10, 2'b01, 3'd0));
                    d = '0; d.adr = 1'b1; d.mw = 1'b1; exp_q.push_back(d);
                end
                7'h33: begin exp_q.push_back(o_alu(2'b10, 2'b00, exp_alu(f3, f7, 1))); exp_q.push_back(wb); end
                7'h13: begin exp_q.push_back(o_alu(2'b10, 2'b01, exp_alu(f3, f7, 0))); exp_q.push_back(wb); end
                7'h63: begin exp_q.push_back(o_alu(2'b10, 2'b00, 3'd1)); br_idx = 2; end
                7'h6f: begin
                    d = o_alu(2'b01, 2'b10, 3'd0); d.pcw = 1'b1;
                    exp_q.push_back(d); exp_q.push_back(wb);
                end
                7'h67: begin
                    exp_q.push_back(o_alu(2'b10, 2'b01, 3'd0));
                    d = o_alu(2'b01, 2'b10, 3'd0); d.pcw = 1'b1;
                    exp_q.push_back(d); exp_q.push_back(wb);
                end
                default: begin
                    d = '0; d.imm = 3'd4; d.rs = 2'b11; d.rw = 1'b1; exp_q.push_back(d);
                end
            endcase
        end
    endtask

    task automatic check_vec(input string name, input int cyc, input outs_t got, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s op=%b f3=%b cyc=%0d got=%h exp=%h", name, op, funct3, cyc + 1, got, exp);
        end
    endtask

    task automatic check1(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after a rising edge
    task automatic do_reset(input int cycles);
        outs_t g;
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            g = sample();
            check_vec("reset", i, g, o_reset());
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] o7, input logic [2:0] f3, input logic f7,
                             input int zv, input int nv, input int abort_at);
        outs_t e, g;
        build(o7, f3, f7);
        op = o7; funct3 = f3; funct7_5 = f7;
        for (int i = 0; i < exp_q.size(); i++) begin
            zero = (zv < 0) ? 1'($urandom_range(0, 1)) : 1'(zv);
            neg  = (nv < 0) ? 1'($urandom_range(0, 1)) : 1'(nv);
            e = exp_q[i];
            if (i == br_idx) e.pcw = exp_taken(f3, zero, neg);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                e = o_reset();
            end
            @(negedge clk);
            g = sample();
            obs[i] = g;
            check_vec(i == abort_at ? "abort" : "outs", i, g, e);
            @(posedge clk); #1;
            if (i == abort_at) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t g;
        logic [6:0] ro;
        int ab;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            g = sample();
            check1("rst_enables", int'({g.pcw, g.irw, g.mw, g.rw, g.ill}), 0);
            check1("rst_srcb", int'(g.sb), 2);
            @(posedge clk);
        end
        #1 rst = 1'b0;

        run_instr(7'h33, 3'd0, 1'b1, -1, -1, -1);
        check1("first_fetch_ir", int'(obs[0].irw), 1);
        check1("first_fetch_pc", int'(obs[0].pcw), 1);
        check1("first_fetch_srcb", int'(obs[0].sb), 2);
        check1("sub_opcode", int'(obs[2].aop), 1);
        check1("sub_rw_c3", int'(obs[2].rw), 0);
        check1("sub_rw_c4", int'(obs[3].rw), 1);
        run_instr(7'h13, 3'd0, 1'b1, -1, -1, -1);
        check1("after_sub_fetch", int'(obs[0].irw), 1);
        check1("addi_opcode", int'(obs[2].aop), 0);

        run_instr(7'h63, 3'd0, 1'b0, 1, -1, -1);
        check1("beq_taken", int'(obs[2].pcw), 1);
        run_instr(7'h63, 3'd1, 1'b0, 1, -1, -1);
        check1("bne_not_taken", int'(obs[2].pcw), 0);
        check1("bne_3cyc_fetch_seen", int'(obs[0].irw), 1);
        run_instr(7'h63, 3'd4, 1'b0, 0, 1, -1);
        check1("blt_taken", int'(obs[2].pcw), 1);

        run_instr(7'h03, 3'd2, 1'b0, -1, -1, -1);
        check1("lw_adr_c4", int'(obs[3].adr), 1);
        check1("lw_adr_c5", int'(obs[4].adr), 1);
        check1("lw_res_c5", int'(obs[4].rs), 1);
        check1("lw_rw_c5", int'(obs[4].rw), 1);

        run_instr(7'h67, 3'd0, 1'b0, -1, -1, -1);
        check1("jalr_pcw_c4", int'(obs[3].pcw), 1);
        check1("jalr_res_c4", int'(obs[3].rs), 0);
        check1("jalr_link_a", int'(obs[3].sa), 1);
        check1("jalr_link_b", int'(obs[3].sb), 2);
        check1("jalr_rw_c5", int'(obs[4].rw), 1);

        run_instr(7'h0f, 3'd0, 1'b0, -1, -1, -1);
        check1("illegal_decode_quiet", int'({obs[1].pcw, obs[1].irw, obs[1].mw, obs[1].rw}), 0);
`ifdef ILLEGAL_TRAP_EN
        check1("trap_ill_c3", int'(obs[2].ill), 1);
        check1("trap_ill_c5", int'(obs[4].ill), 1);
        do_reset(2);
`else
        check1("nop_ill_low", int'(obs[1].ill), 0);
`endif
        run_instr(7'h37, 3'd0, 1'b0, -1, -1, -1);
        check1("after_illegal_fetch", int'(obs[0].irw), 1);
        check1("lui_res", int'(obs[2].rs), 3);

        run_instr(7'h23, 3'd2, 1'b0, -1, -1, 3);
        check1("sw_abort_no_write", int'(obs[3].mw), 0);
        run_instr(7'h03, 3'd2, 1'b0, -1, -1, 4);
        check1("lw_abort_no_write", int'(obs[4].rw), 0);
        run_instr(7'h6f, 3'd0, 1'b0, -1, -1, -1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 8))
                0: ro = 7'h03;
                1: ro = 7'h23;
                2: ro = 7'h33;
                3: ro = 7'h13;
                4: ro = 7'h63;
                5: ro = 7'h6f;
                6: ro = 7'h67;
                7: ro = 7'h37;
                default: ro = ($urandom_range(0, 1) == 0) ? 7'h0f : 7'(($urandom_range(0, 3) << 5) | 7'h17);
            endcase
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_instr(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1, ab);
            if (halted) do_reset(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
